// File: rtl/ca_code_pkg.sv
// Shared constants and helpers for the GPS C/A code generator: LFSR taps, code length and the
// per-PRN G2 phase-select table.
package ca_code_pkg;

  localparam int unsigned CODE_LENGTH = 1023;

  // LFSR state held as bits [10:1] so tap numbers match the ICD polynomials directly.
  typedef logic [10:1] lfsr_t;

  // G1 = 1 + x^3 + x^10, G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10
  localparam lfsr_t G1_TAPS = 10'b10_0000_0100;
  localparam lfsr_t G2_TAPS = 10'b11_1010_0110;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } tap_pair_t;

  // G2 phase-select tap pairs for PRN 1..32, one pair per byte (a in the high nibble).
  localparam logic [7:0] G2_TAP_TABLE [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  function automatic logic prn_valid(input int unsigned prn);
    return (prn >= 1) && (prn <= 32);
  endfunction

  function automatic tap_pair_t g2_taps(input int unsigned prn);
    return tap_pair_t'(G2_TAP_TABLE[5'(prn - 1)]);
  endfunction

  function automatic lfsr_t lfsr_step(input lfsr_t s, input lfsr_t taps);
    return {s[9:1], ^(s & taps)};
  endfunction

  function automatic logic code_chip(input lfsr_t g1, input lfsr_t g2, input int unsigned prn);
    tap_pair_t t;
    if (!prn_valid(prn)) return 1'b0;
    t = g2_taps(prn);
    return g1[10] ^ g2[t.a] ^ g2[t.b];
  endfunction

endpackage

// File: rtl/ca_code_gen_if.sv
// Control/code bus of the C/A code generator. Slew ports exist only with CA_CODE_GEN_SLEW_EN.
interface ca_code_gen_if #(
  parameter int unsigned PRN_WIDTH      = 6,
  parameter int unsigned CHIP_CNT_WIDTH = 10
);
  logic                      enable;
  logic                      init;
  logic [PRN_WIDTH-1:0]      prn;
  logic                      code_msb;
  logic                      early;
  logic                      prompt;
  logic                      late;
  logic [CHIP_CNT_WIDTH-1:0] chip_count;
  logic                      epoch;
`ifdef CA_CODE_GEN_SLEW_EN
  logic                      slew_req;
  logic [10:0]               slew_half;
  logic                      slew_busy;
`endif

  modport master (
    output enable, init, prn, code_msb,
`ifdef CA_CODE_GEN_SLEW_EN
    output slew_req, slew_half,
    input  slew_busy,
`endif
    input  early, prompt, late, chip_count, epoch
  );

  modport slave (
    input  enable, init, prn, code_msb,
`ifdef CA_CODE_GEN_SLEW_EN
    input  slew_req, slew_half,
    output slew_busy,
`endif
    output early, prompt, late, chip_count, epoch
  );

endinterface

// File: rtl/rise_tick.sv
// Rising-edge detector for the code-rate dds MSB; the history register runs even when disabled.
module rise_tick (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sig,
  output logic tick
);

  logic sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign tick = sig & ~sig_q & enable;

endmodule

// File: rtl/ca_code_gen.sv
// GPS C/A code generator producing early/prompt/late chips at half-chip spacing.
// Optional code-phase slew counter is built with CA_CODE_GEN_SLEW_EN.
module ca_code_gen
  import ca_code_pkg::*;
#(
  parameter int unsigned PRN_WIDTH      = 6,
  parameter int unsigned CHIP_CNT_WIDTH = 10
) (
  input  logic       clk,
  input  logic       reset,
  ca_code_gen_if.slave bus
);

  localparam logic [CHIP_CNT_WIDTH-1:0] LastChip = CHIP_CNT_WIDTH'(CODE_LENGTH - 1);

  logic                      dds_tick;
  logic                      tick;
  lfsr_t                     g1_q, g1_d;
  lfsr_t                     g2_q, g2_d;
  logic [PRN_WIDTH-1:0]      prn_q, prn_d;
  logic                      phase_q, phase_d;
  logic [CHIP_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      early_q, early_d;
  logic                      prompt_q, prompt_d;
  logic                      late_q, late_d;
  logic                      epoch_q, epoch_d;

  rise_tick u_rise_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (bus.enable),
    .sig    (bus.code_msb),
    .tick   (dds_tick)
  );

`ifdef CA_CODE_GEN_SLEW_EN
  logic [10:0] slew_cnt_q, slew_cnt_d;

  always_comb begin
    slew_cnt_d = slew_cnt_q;
    if (bus.init) begin
      slew_cnt_d = '0;
    end else if (bus.slew_req) begin
      slew_cnt_d = bus.slew_half;
    end else if (slew_cnt_q != '0) begin
      slew_cnt_d = slew_cnt_q - 11'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slew_cnt_q <= '0;
    end else begin
      slew_cnt_q <= slew_cnt_d;
    end
  end

  // While slewing every cycle is a forced tick, which swallows any dds tick.
  assign tick          = (slew_cnt_q != '0) | dds_tick;
  assign bus.slew_busy = (slew_cnt_q != '0);
`else
  assign tick = dds_tick;
`endif

  always_comb begin
    g1_d     = g1_q;
    g2_d     = g2_q;
    prn_d    = prn_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    early_d  = early_q;
    prompt_d = prompt_q;
    late_d   = late_q;
    epoch_d  = 1'b0;
    if (bus.init) begin
      g1_d     = '1;
      g2_d     = '1;
      prn_d    = bus.prn;
      phase_d  = 1'b0;
      cnt_d    = '0;
      early_d  = code_chip('1, '1, 32'(bus.prn));
      prompt_d = early_d;
      late_d   = early_d;
    end else if (tick) begin
      phase_d  = ~phase_q;
      prompt_d = early_q;
      late_d   = prompt_q;
      if (phase_q) begin
        if (cnt_q == LastChip) begin
          cnt_d   = '0;
          g1_d    = '1;
          g2_d    = '1;
          epoch_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          g1_d  = lfsr_step(g1_q, G1_TAPS);
          g2_d  = lfsr_step(g2_q, G2_TAPS);
        end
        early_d = code_chip(g1_d, g2_d, 32'(prn_q));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g1_q     <= '1;
      g2_q     <= '1;
      prn_q    <= '0;
      phase_q  <= 1'b0;
      cnt_q    <= '0;
      early_q  <= 1'b0;
      prompt_q <= 1'b0;
      late_q   <= 1'b0;
      epoch_q  <= 1'b0;
    end else begin
      g1_q     <= g1_d;
      g2_q     <= g2_d;
      prn_q    <= prn_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      early_q  <= early_d;
      prompt_q <= prompt_d;
      late_q   <= late_d;
      epoch_q  <= epoch_d;
    end
  end

  assign bus.early      = early_q;
  assign bus.prompt     = prompt_q;
  assign bus.late       = late_q;
  assign bus.chip_count = cnt_q;
  assign bus.epoch      = epoch_q;

endmodule

// File: tb/tb_ca_code_gen.sv
// Directed self-checking bench for ca_code_gen; slew checks compile in with CA_CODE_GEN_SLEW_EN.
module tb_ca_code_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  ca_code_gen_if #(.PRN_WIDTH(6), .CHIP_CNT_WIDTH(10)) bus ();

  ca_code_gen #(.PRN_WIDTH(6), .CHIP_CNT_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.code_msb = 1'b1;
    step();
    bus.code_msb = 1'b0;
    step();
  endtask

  task automatic do_init(input logic [5:0] p);
    bus.prn  = p;
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
  endtask

  // pat holds chips 0..9 with chip 0 in bit 9.
  task automatic run_seq(input logic [5:0] p, input logic [9:0] pat);
    do_init(p);
    chk("init_early", bus.early, pat[9]);
    chk("init_late", bus.late, pat[9]);
    chk("init_count", bus.chip_count, 0);
    for (int m = 1; m <= 20; m++) begin
      tick_once();
      if (m < 20) chk("seq_early", bus.early, pat[9 - m / 2]);
      chk("seq_prompt", bus.prompt, pat[9 - (m - 1) / 2]);
      chk("seq_late", bus.late, (m == 1) ? pat[9] : pat[9 - (m - 2) / 2]);
    end
    chk("seq_count20", bus.chip_count, 10);
  endtask

  initial begin
    logic [9:0] pat1;
    logic [9:0] pat2;
    int         ep_cnt;
    int         ep_tick;
    pat1 = 10'b1100100000;
    pat2 = 10'b1110010000;

    bus.enable   = 1'b0;
    bus.init     = 1'b0;
    bus.prn      = '0;
    bus.code_msb = 1'b0;
`ifdef CA_CODE_GEN_SLEW_EN
    bus.slew_req  = 1'b0;
    bus.slew_half = '0;
`endif
    step();
    step();
    chk("rst_early", bus.early, 0);
    chk("rst_prompt", bus.prompt, 0);
    chk("rst_late", bus.late, 0);
    chk("rst_count", bus.chip_count, 0);
    chk("rst_epoch", bus.epoch, 0);
    reset      = 1'b0;
    bus.enable = 1'b1;

    // No init after reset: latched PRN is invalid, code runs but chips read 0.
    for (int i = 0; i < 4; i++) tick_once();
    chk("noinit_count", bus.chip_count, 2);
    chk("noinit_early", bus.early, 0);

    run_seq(6'd1, pat1);
    run_seq(6'd2, pat2);

    do_init(6'd33);
    chk("prn33_early", bus.early, 0);
    for (int i = 0; i < 3; i++) tick_once();
    chk("prn33_count", bus.chip_count, 1);
    chk("prn33_late", bus.late, 0);
    do_init(6'd0);
    chk("prn0_prompt", bus.prompt, 0);

    // Full code period: a single epoch on the 1022 -> 0 step.
    do_init(6'd1);
    ep_cnt  = 0;
    ep_tick = 0;
    for (int i = 1; i <= 2046; i++) begin
      bus.code_msb = 1'b1;
      step();
      if (bus.epoch) begin
        ep_cnt++;
        ep_tick = i;
      end
      bus.code_msb = 1'b0;
      step();
      if (bus.epoch) ep_cnt++;
      if (i == 2044) chk("ep_count1022", bus.chip_count, 1022);
    end
    chk("ep_pulses", ep_cnt, 1);
    chk("ep_tick", ep_tick, 2046);
    chk("ep_wrap_count", bus.chip_count, 0);
    chk("ep_wrap_early", bus.early, 1);

    // code_msb activity while disabled must not leave a pending tick.
    do_init(6'd1);
    bus.enable   = 1'b0;
    bus.code_msb = 1'b1;
    for (int i = 0; i < 5; i++) step();
    for (int i = 0; i < 6; i++) begin
      bus.code_msb = ~bus.code_msb;
      step();
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("en_count_hold", bus.chip_count, 0);
    bus.code_msb = 1'b0;
    step();
    tick_once();
    chk("en_first_tick", bus.chip_count, 0);
    tick_once();
    chk("en_second_tick", bus.chip_count, 1);
    chk("en_chip1", bus.early, 1);

    // init collides with a full-chip tick at chip 500.
    do_init(6'd1);
    for (int i = 0; i < 1001; i++) tick_once();
    chk("col_pre_count", bus.chip_count, 500);
    bus.code_msb = 1'b1;
    bus.init     = 1'b1;
    step();
    chk("col_count", bus.chip_count, 0);
    chk("col_epoch", bus.epoch, 0);
    chk("col_early", bus.early, 1);
    chk("col_late", bus.late, 1);
    bus.init     = 1'b0;
    bus.code_msb = 1'b0;
    step();
    chk("col_epoch2", bus.epoch, 0);
    tick_once();
    chk("col_phase_cleared", bus.chip_count, 0);
    tick_once();
    chk("col_next_chip", bus.chip_count, 1);

    // Asynchronous reset mid-code, then no PRN until the next init.
    do_init(6'd1);
    tick_once();
    tick_once();
    chk("ar_pre_count", bus.chip_count, 1);
    chk("ar_pre_prompt", bus.prompt, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_count", bus.chip_count, 0);
    chk("ar_early", bus.early, 0);
    chk("ar_prompt", bus.prompt, 0);
    chk("ar_late", bus.late, 0);
    step();
    reset = 1'b0;
    tick_once();
    tick_once();
    chk("ar_post_count", bus.chip_count, 1);
    chk("ar_post_early", bus.early, 0);

`ifdef CA_CODE_GEN_SLEW_EN
    begin
      int busy_cycles;
      do_init(6'd1);
      bus.slew_half = 11'd20;
      bus.slew_req  = 1'b1;
      step();
      bus.slew_req = 1'b0;
      busy_cycles  = 0;
      if (bus.slew_busy) busy_cycles++;
      for (int i = 0; i < 29; i++) begin
        step();
        if (bus.slew_busy) busy_cycles++;
      end
      chk("slew_busy_cycles", busy_cycles, 20);
      chk("slew_count", bus.chip_count, 10);
      chk("slew_early", bus.early, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
CA_CODE_GEN -- requirements
Module: ca_code_gen

Interface
REQ-001 SHALL have parameter PRN_WIDTH, default 6, meaning the width of the PRN select input (PRN 1..32 valid).
REQ-002 SHALL have parameter CHIP_CNT_WIDTH, default 10, meaning the width of chip_count (0..1022).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1: when low, ticks are ignored.
REQ-006 SHALL have port init, input, 1: synchronous restart to chip 0 with the PRN latched from prn.
REQ-007 SHALL have port prn, input, PRN_WIDTH: satellite select, sampled only when init=1.
REQ-008 SHALL have port code_msb, input, 1: MSB of the upstream code-rate dds, running at 2x chip rate; each rising edge is one half-chip tick.
REQ-009 SHALL have ports early, prompt and late, each output, 1: code chips at half-chip spacing.
REQ-010 SHALL have port chip_count, output, CHIP_CNT_WIDTH: index of the early chip.
REQ-011 SHALL have port epoch, output, 1: one-cycle pulse at each code epoch.

Function
REQ-012 SHALL register code_msb each cycle; tick = code_msb & ~code_msb_q & enable. code_msb_q SHALL update even while enable=0, so re-enabling never produces a false tick.
REQ-013 SHALL implement G1 = 1+x^3+x^10 and G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10 as 10-bit LFSRs.
REQ-014 SHALL form early = G1[10] XOR (G2[a] XOR G2[b]), where (a,b) is the ICD-GPS-200 phase-select tap pair for the latched PRN (PRN1 = 2,6; PRN2 = 3,7; PRN3 = 4,8; PRN4 = 5,9; ...).
REQ-015 SHALL keep a half-chip phase bit that toggles on every tick; the LFSRs SHALL step, and chip_count SHALL increment, only on ticks where the phase bit is 1 (every second tick).
REQ-016 On every tick, prompt SHALL take the previous early value and late SHALL take the previous prompt value, giving half-chip and one-chip delays.
REQ-017 All outputs SHALL be registered, updating on the same clock edge at which the tick is sampled.
REQ-018 On a full-chip step with chip_count=1022, chip_count SHALL wrap to 0, both LFSRs SHALL reload all-ones, and epoch SHALL pulse for exactly one cycle.
REQ-019 init SHALL load both LFSRs all-ones, clear chip_count and the phase bit, latch prn, and set early, prompt and late all to chip 0 of the new PRN; init SHALL NOT pulse epoch.
REQ-020 init SHALL take priority over a simultaneous tick; that tick SHALL be discarded.
REQ-021 For a latched prn of 0 or above 32, the LFSRs SHALL still run but early, prompt and late SHALL be forced to 0.

Reset
REQ-022 Asserting reset SHALL immediately set: G1 and G2 all-ones, latched prn 0 (invalid), phase bit 0, chip_count 0, early/prompt/late 0, epoch 0, code_msb_q 0.
REQ-023 Reset mid-code SHALL abandon code state; a new init is required to select a PRN.

Configuration
REQ-024 With macro CA_CODE_GEN_SLEW_EN defined, the block SHALL add inputs slew_req (1) and slew_half (11), and output slew_busy (1).
REQ-025 With CA_CODE_GEN_SLEW_EN, slew_req SHALL load slew_half into a counter; while the counter is nonzero, each cycle SHALL act as one tick and decrement it, slew_busy SHALL be 1, and dds ticks SHALL be dropped. init SHALL clear the counter.
REQ-026 Without CA_CODE_GEN_SLEW_EN, these ports and the counter SHALL be absent.

Structure
REQ-027 Package ca_code_pkg SHALL hold CODE_LENGTH=1023, the G1/G2 polynomial constants, and the 32-entry G2 tap-pair table as a constant/function.
REQ-028 The tick edge detector SHALL be sub-module rise_tick (in: clk, reset, enable, sig; out: tick).

Verification
REQ-029 Reset, then init with prn=1, then 20 ticks: the early chips 0..9 SHALL read 1100100000 (octal 1440), and prompt/late SHALL repeat early delayed by 1 and 2 ticks.
REQ-030 init with prn=2, then 20 ticks: the first 10 early chips SHALL be 1110010000 (octal 1620).
REQ-031 prn=1, 2046 ticks: epoch SHALL pulse exactly once, on the tick where chip_count goes 1022->0, and early SHALL then equal 1 (chip 0).
REQ-032 Hold code_msb high for 5 cycles, then toggle it while enable=0, then raise enable while code_msb=1: no tick SHALL occur and chip_count SHALL stay 0.
REQ-033 Assert init on the same cycle as a tick at chip_count=500: chip_count SHALL become 0, the tick SHALL be lost, and epoch SHALL stay 0.
REQ-034 With CA_CODE_GEN_SLEW_EN defined, prn=1, slew_half=20: slew_busy SHALL be high for 20 cycles, chip_count SHALL become 10, and early SHALL equal chip 10 of PRN1.
